// File: rtl/uart_state_tx_if.sv
// Telemetry UART transmitter bus: request, coordinates and line status.
// The master drives requests, the slave (transmitter) drives the line.
interface uart_state_tx_if;
    logic       send;
    logic [8:0] x;
    logic [8:0] y;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output send, x, y,
        input  tx, busy, done
    );

    modport slave (
        input  send, x, y,
        output tx, busy, done
    );
endinterface

// File: rtl/uart_state_tx.sv
// Serial telemetry transmitter: 5-byte 8N1 packet carrying a latched
// x/y pair (header, high bits, x low, y low, xor checksum).
module uart_state_tx #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    uart_state_tx_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [8:0]    x_q;
    logic [8:0]    y_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    cur_byte;
    logic          wrap;

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    assign wrap = (cnt == TC);

    // Byte currently being serialised, built from the latched coordinates.
    always_comb begin
        cur_byte = HEADER;
        case (byte_idx)
            3'd0: cur_byte = HEADER;
            3'd1: cur_byte = {6'b0, x_q[8], y_q[8]};
            3'd2: cur_byte = x_q[7:0];
            3'd3: cur_byte = y_q[7:0];
            default: cur_byte = HEADER
                              ^ {6'b0, x_q[8], y_q[8]}
                              ^ x_q[7:0]
                              ^ y_q[7:0];
        endcase
    end

    // Packet FSM with bit-time counter; tx/busy/done are all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            x_q      <= '0;
            y_q      <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    cnt  <= '0;
                    if (bus.send) begin
                        x_q      <= bus.x;
                        y_q      <= bus.y;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (wrap) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_q    <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (wrap) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        cnt <= '0;
                        if (byte_idx == 3'd4) begin
                            tx_q   <= 1'b1;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_q     <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_state_tx.sv
// Self-checking bench for uart_state_tx: decodes the serial line and
// compares against a packet model built from the coordinates.
module tb_uart_state_tx;
    localparam int C   = 4;
    localparam int PKT = 50 * C;
    localparam int TMO = 2000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   busy_cnt;
    int   done_cnt;

    uart_state_tx_if bus ();

    uart_state_tx #(
        .CLKS_PER_BIT(C),
        .HEADER      (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count and line activity counters.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic logic [39:0] model_pkt(input logic [8:0] x,
                                              input logic [8:0] y);
        int b0, b1, b2, b3, b4;
        b0 = 165;
        b1 = (int'(x) / 256) * 2 + (int'(y) / 256);
        b2 = int'(x) % 256;
        b3 = int'(y) % 256;
        b4 = b0 ^ b1 ^ b2 ^ b3;
        return {b4[7:0], b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
    endfunction

    // Receive one packet starting from the current negedge.
    task automatic rx_packet(output logic [39:0] pk, output int st,
                             output bit ok);
        int w;
        logic [7:0] b;
        ok = 1'b1;
        pk = '0;
        st = -1;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (bus.tx !== 1'b0 && w < TMO) begin
                @(negedge clk);
                w++;
            end
            if (bus.tx !== 1'b0) begin
                ok = 1'b0;
                return;
            end
            if (k == 0) st = cyc;
            repeat (C / 2) @(negedge clk);
            if (bus.tx !== 1'b0) ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
                repeat (C) @(negedge clk);
                b[j] = bus.tx;
            end
            repeat (C) @(negedge clk);
            if (bus.tx !== 1'b1) ok = 1'b0;
            pk[k*8 +: 8] = b;
        end
    endtask

    task automatic wait_done(output bit ok, output int at);
        int w;
        w = 0;
        at = -1;
        while (bus.done !== 1'b1 && w < TMO) begin
            @(negedge clk);
            w++;
        end
        ok = (bus.done === 1'b1);
        if (ok) at = cyc;
    endtask

    task automatic pulse_send(input logic [8:0] x, input logic [8:0] y);
        bus.x    = x;
        bus.y    = y;
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
                errors++;
                $display("FAIL idle_%0d tx/busy/done=%b required 100",
                         i, {bus.tx, bus.busy, bus.done});
            end
        end
        rst      = 1'b1;
        bus.send = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bus.send = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.tx, bus.busy} !== 2'b10) begin
                errors++;
                $display("FAIL rst_send_%0d tx/busy=%b required 10",
                         i, {bus.tx, bus.busy});
            end
        end
    endtask

    task automatic test_single(input logic [8:0] x, input logic [8:0] y);
        logic [39:0] pk;
        logic [39:0] exp;
        int st, at, b0, d0;
        bit ok, okd;
        exp = model_pkt(x, y);
        b0  = busy_cnt;
        d0  = done_cnt;
        pulse_send(x, y);
        rx_packet(pk, st, ok);
        checks++;
        if (!ok || pk !== exp) begin
            errors++;
            $display("FAIL single pkt=%h ok=%0d required %h", pk, ok, exp);
        end
        wait_done(okd, at);
        checks++;
        if (!okd || at - st !== PKT) begin
            errors++;
            $display("FAIL single_done at=%0d st=%0d required delta %0d",
                     at, st, PKT);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_cnt - b0 !== PKT || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL single_cnt busy=%0d done=%0d required %0d 1",
                     busy_cnt - b0, done_cnt - d0, PKT);
        end
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle tx=%b busy=%b required 1 0",
                     bus.tx, bus.busy);
        end
    endtask

    task automatic test_isolation();
        logic [39:0] pk;
        logic [39:0] exp;
        logic [8:0]  x, y;
        int st, at;
        bit ok, okd;
        x   = 9'($urandom_range(1, 511));
        y   = 9'($urandom_range(1, 511));
        exp = model_pkt(x, y);
        pulse_send(x, y);
        bus.x = '0;
        bus.y = '0;
        rx_packet(pk, st, ok);
        checks++;
        if (!ok || pk !== exp) begin
            errors++;
            $display("FAIL isolation pkt=%h ok=%0d required %h", pk, ok, exp);
        end
        wait_done(okd, at);
        @(negedge clk);
    endtask

    task automatic test_ignored();
        logic [39:0] pk;
        logic [39:0] exp;
        logic [8:0]  x, y;
        int st, at, b0, d0;
        bit ok, okd;
        x   = 9'($urandom);
        y   = 9'($urandom);
        exp = model_pkt(x, y);
        b0  = busy_cnt;
        d0  = done_cnt;
        pulse_send(x, y);
        repeat (49) @(negedge clk);
        pulse_send(~x, ~y);
        wait_done(okd, at);
        repeat (2 * PKT) @(negedge clk);
        checks++;
        if (!okd || done_cnt - d0 !== 1 || busy_cnt - b0 !== PKT) begin
            errors++;
            $display("FAIL ignored done=%0d busy=%0d required 1 %0d",
                     done_cnt - d0, busy_cnt - b0, PKT);
        end
        checks++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_idle tx=%b busy=%b required 1 0",
                     bus.tx, bus.busy);
        end
        pulse_send(x, y);
        rx_packet(pk, st, ok);
        checks++;
        if (!ok || pk !== exp) begin
            errors++;
            $display("FAIL ignored_pkt pkt=%h required %h", pk, exp);
        end
        wait_done(okd, at);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [39:0] pk1, pk2;
        logic [39:0] lit;
        int st1, st2, at;
        bit ok1, ok2, okd;
        lit      = 40'h58_00_FF_02_A5;
        bus.x    = 9'h1FF;
        bus.y    = 9'h000;
        bus.send = 1'b1;
        @(negedge clk);
        rx_packet(pk1, st1, ok1);
        wait_done(okd, at);
        @(negedge clk);
        bus.send = 1'b0;
        rx_packet(pk2, st2, ok2);
        checks++;
        if (!ok1 || pk1 !== lit) begin
            errors++;
            $display("FAIL b2b_pkt1 pkt=%h required %h", pk1, lit);
        end
        checks++;
        if (!ok2 || pk2 !== lit) begin
            errors++;
            $display("FAIL b2b_pkt2 pkt=%h required %h", pk2, lit);
        end
        checks++;
        if (st2 - st1 !== PKT + 1 || at - st1 !== PKT) begin
            errors++;
            $display("FAIL b2b_gap period=%0d done=%0d required %0d %0d",
                     st2 - st1, at - st1, PKT + 1, PKT);
        end
        wait_done(okd, at);
        repeat (PKT) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end busy=%b tx=%b required 0 1",
                     bus.busy, bus.tx);
        end
    endtask

    task automatic test_mid_reset();
        logic [39:0] pk;
        logic [39:0] exp;
        logic [8:0]  x, y;
        int st, at, d0;
        bit ok, okd;
        x  = 9'($urandom);
        y  = 9'($urandom);
        d0 = done_cnt;
        pulse_send(x, y);
        repeat (97) @(negedge clk);
        checks++;
        if (bus.tx !== x[3] || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit tx=%b busy=%b required %b 1",
                     bus.tx, bus.busy, x[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.tx, bus.busy, bus.done} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset tx/busy/done=%b required 100",
                     {bus.tx, bus.busy, bus.done});
        end
        repeat (PKT) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 0 || bus.tx !== 1'b1) begin
            errors++;
            $display("FAIL mid_nodone done=%0d tx=%b required 0 1",
                     done_cnt - d0, bus.tx);
        end
        x   = 9'($urandom);
        y   = 9'($urandom);
        exp = model_pkt(x, y);
        pulse_send(x, y);
        rx_packet(pk, st, ok);
        checks++;
        if (!ok || pk !== exp) begin
            errors++;
            $display("FAIL mid_after pkt=%h required %h", pk, exp);
        end
        wait_done(okd, at);
        checks++;
        if (!okd) begin
            errors++;
            $display("FAIL mid_after_done done=%b required 1", bus.done);
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        busy_cnt = 0;
        done_cnt = 0;
        rst      = 1'b1;
        bus.send = 1'b0;
        bus.x    = '0;
        bus.y    = '0;
        @(negedge clk);
        test_reset();
        test_single(9'h12D, 9'h0C8);
        for (int i = 0; i < 3; i++)
            test_single(9'($urandom), 9'($urandom));
        test_single(9'h1FF, 9'h1FF);
        test_isolation();
        test_ignored();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
